sel_arbiter: RTL and testbench

- Round-robin arbiter for the shared 2-bit select path of the processor datapath.
- Three requesters each present a 2-bit select code.
- The block grants one requester at a time, latches that requester's code onto the shared select output, and holds it until the owner releases.
- Replaces ad-hoc OR-merging of select codes, so simultaneous requesters can no longer corrupt the select value.

---
 rtl/sel_arbiter.sv | 162 ++++++++++++++++
 tb/tb_sel_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sel_arbiter.sv
// sel_arbiter: round-robin arbiter for the shared 2-bit select path.
// Three requesters each present a 2-bit select code. One requester at a
// time is granted, and its code is latched onto sel_out until the owner
// releases the path with done, or drops req.
//
// Ports:
//   clk      rising-edge system clock
//   reset    asynchronous, active-high reset
//   req      [2:0] request per requester (bit i = requester i)
//   code     [5:0] select codes, code[2i+1:2i] belongs to requester i
//   done     [2:0] one-cycle release pulse per requester
//   grant    [2:0] registered one-hot grant
//   sel_out  [1:0] registered shared select value
//   busy     high while any grant is active (== |grant)
//   timeout  one-cycle pulse on a forced release
//
// Optional feature: define SEL_ARB_TIMEOUT_EN to force a release after
// MAX_HOLD cycles in HOLD. Without it, timeout is tied 0 and a grant is
// held until a normal release.
module sel_arbiter #(
   parameter logic [1:0]  DEFAULT_SEL = 2'b00,
   parameter int unsigned MAX_HOLD    = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] req,
   input  logic [5:0] code,
   input  logic [2:0] done,
   output logic [2:0] grant,
   output logic [1:0] sel_out,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t     state, state_n;
   logic [1:0] ptr, ptr_n;
   logic [1:0] owner, owner_n;
   logic [2:0] grant_n;
   logic [1:0] sel_n;
   logic [1:0] cand0, cand1, cand2, winner;
   logic       release_ok;

   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("sel_arbiter: MAX_HOLD must be in 1..255");
   end

`ifdef SEL_ARB_TIMEOUT_EN
   logic [7:0] hold_cnt, hold_cnt_n;
   logic       timeout_n;
`endif

   function automatic logic [1:0] rr_next(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   function automatic logic [1:0] code_of(input logic [5:0] c, input logic [1:0] idx);
      case (idx)
         2'd0:    return c[1:0];
         2'd1:    return c[3:2];
         default: return c[5:4];
      endcase
   endfunction

   always_comb begin
      // Search order starts at ptr and wraps mod 3.
      cand0 = ptr;
      cand1 = rr_next(cand0);
      cand2 = rr_next(cand1);
      if (req[cand0])
         winner = cand0;
      else if (req[cand1])
         winner = cand1;
      else
         winner = cand2;

      // A simultaneous done and req drop is a single release.
      release_ok = done[owner] | ~req[owner];

      state_n = state;
      ptr_n   = ptr;
      owner_n = owner;
      grant_n = grant;
      sel_n   = sel_out;
`ifdef SEL_ARB_TIMEOUT_EN
      hold_cnt_n = hold_cnt;
      timeout_n  = 1'b0;
`endif

      case (state)
         IDLE: begin
            if (|req) begin
               state_n = HOLD;
               owner_n = winner;
               grant_n = 3'b001 << winner;
               sel_n   = code_of(code, winner);
`ifdef SEL_ARB_TIMEOUT_EN
               hold_cnt_n = '0;
`endif
            end
         end
         HOLD: begin
            if (release_ok) begin
               state_n = IDLE;
               grant_n = '0;
               sel_n   = DEFAULT_SEL;
               ptr_n   = rr_next(owner);
            end
`ifdef SEL_ARB_TIMEOUT_EN
            else if (hold_cnt == 8'(MAX_HOLD - 1)) begin
               state_n   = IDLE;
               grant_n   = '0;
               sel_n     = DEFAULT_SEL;
               ptr_n     = rr_next(owner);
               timeout_n = 1'b1;
            end else begin
               hold_cnt_n = hold_cnt + 8'd1;
            end
`endif
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
            sel_n   = DEFAULT_SEL;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         ptr     <= '0;
         owner   <= '0;
         grant   <= '0;
         sel_out <= DEFAULT_SEL;
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         owner   <= owner_n;
         grant   <= grant_n;
         sel_out <= sel_n;
      end
   end

`ifdef SEL_ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         hold_cnt <= hold_cnt_n;
         timeout  <= timeout_n;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   assign busy = |grant;

endmodule

// File: tb/tb_sel_arbiter.sv
// Testbench for sel_arbiter: directed vectors with literal expectations
// plus a per-cycle comparison against an abstract ownership model.
module tb_sel_arbiter;

   localparam logic [1:0]  DSEL = 2'b00;
   localparam int unsigned MH   = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] req;
   logic [5:0] code;
   logic [2:0] done;
   logic [2:0] grant;
   logic [1:0] sel_out;
   logic       busy;
   logic       timeout;

   int pass_cnt  = 0;
   int total_cnt = 0;

   sel_arbiter #(.DEFAULT_SEL(DSEL), .MAX_HOLD(MH)) dut (
      .clk(clk), .reset(reset), .req(req), .code(code), .done(done),
      .grant(grant), .sel_out(sel_out), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   // Abstract model: who owns the path (-1 = nobody), where the next
   // search starts, the latched code and how long the owner has held.
   int         m_owner = -1;
   int         m_ptr   = 0;
   logic [1:0] m_sel   = DSEL;
   int         m_hold  = 0;
   logic       m_tout  = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_owner = -1; m_ptr = 0; m_sel = DSEL; m_hold = 0; m_tout = 1'b0;
      end else begin
         m_tout = 1'b0;
         if (m_owner < 0) begin
            for (int k = 0; k < 3; k++) begin
               int idx;
               idx = (m_ptr + k) % 3;
               if (m_owner < 0 && req[idx]) begin
                  m_owner = idx;
                  m_sel   = code[2*idx +: 2];
                  m_hold  = 0;
               end
            end
         end else if (done[m_owner] || !req[m_owner]) begin
            m_ptr = (m_owner + 1) % 3; m_owner = -1; m_sel = DSEL;
         end else begin
`ifdef SEL_ARB_TIMEOUT_EN
            if (m_hold == MH - 1) begin
               m_ptr = (m_owner + 1) % 3; m_owner = -1; m_sel = DSEL; m_tout = 1'b1;
            end else
               m_hold++;
`endif
         end
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      logic [2:0] eg;
      eg = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
      check("model_grant", {5'd0, grant}, {5'd0, eg});
      check("model_sel", {6'd0, sel_out}, {6'd0, m_sel});
      check("model_busy", {7'd0, busy}, {7'd0, (m_owner >= 0)});
      check("model_timeout", {7'd0, timeout}, {7'd0, m_tout});
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string name, input logic [2:0] g, input logic [1:0] s);
      check({name, "_grant"}, {5'd0, grant}, {5'd0, g});
      check({name, "_sel"}, {6'd0, sel_out}, {6'd0, s});
      check({name, "_busy"}, {7'd0, busy}, {7'd0, |g});
   endtask

   logic [2:0] rot_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
   logic [1:0] rot_s [4] = '{2'b01, 2'b10, 2'b11, 2'b01};

   initial begin
      reset = 1'b1; req = '0; code = '0; done = '0;
      #12;
      expect_out("reset", 3'b000, DSEL);
      check("reset_timeout", {7'd0, timeout}, 8'd0);
      step();
      reset = 1'b0;

      // Single requester 1 with code 11, released by done.
      req = 3'b010; code = 6'b00_11_00;
      step(); expect_out("single_grant", 3'b010, 2'b11);
      done = 3'b010;
      step(); expect_out("single_release", 3'b000, 2'b00);
      done = 3'b000; req = 3'b000;
      step();
      done = 3'b001;                       // done in IDLE is ignored
      step(); expect_out("idle_done", 3'b000, 2'b00);
      done = 3'b000;

      // Fresh pointer, all three requesting: rotation 0,1,2,0.
      reset = 1'b1; #1; reset = 1'b0;
      req = 3'b111; code = 6'b11_10_01;
      for (int i = 0; i < 4; i++) begin
         step(); expect_out("rot_grant", rot_g[i], rot_s[i]);
         if (i < 3) begin
            step(); expect_out("rot_hold", rot_g[i], rot_s[i]);
            done = rot_g[i];
            step(); expect_out("rot_gap", 3'b000, DSEL);
            done = 3'b000;
         end
      end

      // Owner 0 code changes, non-owner done and req changes: no effect.
      code = 6'b11_10_00; done = 3'b010; req = 3'b101;
      step(); expect_out("frozen1", 3'b001, 2'b01);
      done = 3'b000;
      step(); expect_out("frozen2", 3'b001, 2'b01);

      // Owner 0 drops req: release, then requester 1 two cycles after drop.
      req = 3'b110; code = 6'b11_10_01;
      step(); expect_out("abort_release", 3'b000, DSEL);
      step(); expect_out("abort_next", 3'b010, 2'b10);

      // Asynchronous reset mid-HOLD, then req 101 grants requester 0.
      reset = 1'b1; #1;
      expect_out("async_reset", 3'b000, DSEL);
      req = 3'b101;
      step();
      reset = 1'b0;
      step(); expect_out("post_reset", 3'b001, 2'b01);
      done = 3'b001;
      step(); expect_out("post_reset_rel", 3'b000, DSEL);
      done = 3'b000; req = 3'b000;
      step();

`ifdef SEL_ARB_TIMEOUT_EN
      // Owner 1 never releases: 4 HOLD cycles, timeout pulse, then owner 0.
      req = 3'b011; code = 6'b00_10_01;
      for (int i = 0; i < 4; i++) begin
         step(); expect_out("to_hold", 3'b010, 2'b10);
         check("to_hold_pulse", {7'd0, timeout}, 8'd0);
      end
      step(); expect_out("to_release", 3'b000, DSEL);
      check("to_pulse", {7'd0, timeout}, 8'd1);
      step(); expect_out("to_next", 3'b001, 2'b01);
      check("to_pulse_end", {7'd0, timeout}, 8'd0);
      req = 3'b000;
      step(); step();
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
